// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_SLT   = 3'd4;
    localparam logic [2:0] ALU_FUNCT = 3'd5;

    localparam logic [1:0] RD_RT  = 2'd0;
    localparam logic [1:0] RD_RD  = 2'd1;
    localparam logic [1:0] RD_R31 = 2'd2;

    // Watchdog counter width; covers TIMEOUT up to 255.
    localparam int unsigned WDOG_W = 8;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE, C_JR, C_J, C_JAL, C_LW, C_SW, C_ADDI, C_ORI
    } iclass_t;

endpackage

// File: rtl/mips_mc_decode.sv
// Opcode/funct classifier; purely combinational.
module mips_mc_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass_c,
    output logic       illegal_c
);

    // Map opcode (and funct for special) onto an instruction class.
    always_comb begin
        iclass_c  = C_RTYPE;
        illegal_c = 1'b0;
        case (opcode)
            OP_RTYPE: iclass_c = (funct == FUNCT_JR) ? C_JR : C_RTYPE;
            OP_J:     iclass_c = C_J;
            OP_JAL:   iclass_c = C_JAL;
            OP_LW:    iclass_c = C_LW;
            OP_SW:    iclass_c = C_SW;
            OP_ADDI:  iclass_c = C_ADDI;
            OP_ORI:   iclass_c = C_ORI;
            default:  illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle control sequencer with fetch/data handshakes and bus watchdog.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] instruction,
    output logic        pc_en,
    output logic        reg_write,
    output logic        jal,
    output logic        jr,
    output logic        alu_src_imm,
    output logic        mem_to_reg,
    output logic [1:0]  reg_dst,
    output logic [2:0]  alu_op,
    output logic        illegal,
    output logic        bus_fault
);

    localparam logic [WDOG_W-1:0] TO_LAST = WDOG_W'(TIMEOUT - 1);

    state_t             state, state_d;
    iclass_t            iclass_q, iclass_d;
    iclass_t            dec_class;
    logic               dec_illegal;
    logic [31:0]        inst_d;
    logic               illegal_d, bus_fault_d;
    logic [WDOG_W-1:0]  wdog_cnt, wdog_d;
    // Low for the single cycle after reset so all outputs read 0 there.
    logic               run_q;

    mips_mc_decode u_decode (
        .opcode    (instruction[31:26]),
        .funct     (instruction[5:0]),
        .iclass_c  (dec_class),
        .illegal_c (dec_illegal)
    );

    // State, instruction register, sticky flags and watchdog count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            iclass_q    <= C_RTYPE;
            instruction <= '0;
            illegal     <= 1'b0;
            bus_fault   <= 1'b0;
            wdog_cnt    <= '0;
            run_q       <= 1'b0;
        end else begin
            state       <= state_d;
            iclass_q    <= iclass_d;
            instruction <= inst_d;
            illegal     <= illegal_d;
            bus_fault   <= bus_fault_d;
            wdog_cnt    <= wdog_d;
            run_q       <= 1'b1;
        end
    end

    // Next-state and Moore output decode; SW pc_en qualifies on dmem_ack.
    always_comb begin
        state_d     = state;
        iclass_d    = iclass_q;
        inst_d      = instruction;
        illegal_d   = illegal;
        bus_fault_d = bus_fault;
        wdog_d      = wdog_cnt;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        pc_en       = 1'b0;
        reg_write   = 1'b0;
        jal         = 1'b0;
        jr          = 1'b0;
        alu_src_imm = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = RD_RT;
        alu_op      = ALU_ADD;

        case (state)
            S_FETCH: begin
                if (run_q) begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        inst_d  = imem_rdata;
                        state_d = S_DECODE;
                    end else if (wdog_cnt == TO_LAST) begin
                        bus_fault_d = 1'b1;
                        state_d     = S_HALT;
                    end else begin
                        wdog_d = wdog_cnt + WDOG_W'(1);
                    end
                end
            end
            S_DECODE: begin
                iclass_d = dec_class;
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (iclass_q)
                    C_RTYPE:            alu_op = ALU_FUNCT;
                    C_ADDI, C_LW, C_SW: alu_src_imm = 1'b1;
                    C_ORI: begin
                        alu_op      = ALU_OR;
                        alu_src_imm = 1'b1;
                    end
                    default:            alu_op = ALU_ADD;
                endcase
                case (iclass_q)
                    C_J: begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end
                    C_JR: begin
                        pc_en   = 1'b1;
                        jr      = 1'b1;
                        state_d = S_FETCH;
                    end
                    C_LW, C_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (iclass_q == C_SW);
                if (dmem_ack) begin
                    if (iclass_q == C_SW) begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wdog_cnt == TO_LAST) begin
                    bus_fault_d = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    wdog_d = wdog_cnt + WDOG_W'(1);
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_en      = 1'b1;
                jal        = (iclass_q == C_JAL);
                mem_to_reg = (iclass_q == C_LW);
                reg_dst    = (iclass_q == C_RTYPE) ? RD_RD :
                             (iclass_q == C_JAL)   ? RD_R31 : RD_RT;
                state_d    = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // Every entry into a requesting state starts a fresh watchdog window.
        if ((state_d != state) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
            wdog_d = '0;
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized bench for mips_mc_ctrl against a per-instruction schedule model.
module tb_mips_mc_ctrl;

    localparam int unsigned TO = 4;

    // Observed-vector bit positions.
    localparam int B_IREQ = 15, B_DREQ = 14, B_DWE = 13, B_PCE = 12, B_RW = 11;
    localparam int B_JAL = 10, B_JR = 9, B_SRC = 8, B_M2R = 7;

    localparam int K_R = 0, K_JR = 1, K_J = 2, K_JAL = 3, K_LW = 4;
    localparam int K_SW = 5, K_ADDI = 6, K_ORI = 7, K_ILL = 8;

    logic        clk, reset, imem_ack, dmem_ack;
    logic [31:0] imem_rdata, instruction;
    logic        imem_req, dmem_req, dmem_we, pc_en, reg_write, jal, jr;
    logic        alu_src_imm, mem_to_reg, illegal, bus_fault;
    logic [1:0]  reg_dst;
    logic [2:0]  alu_op;
    logic [15:0] obs;

    int          errors, checks, ncyc, pc_pulses, retired;
    logic [31:0] m_inst, cur_word;
    logic        m_ill, m_bf;

    mips_mc_ctrl #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .dmem_ack    (dmem_ack),
        .imem_req    (imem_req),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .instruction (instruction),
        .pc_en       (pc_en),
        .reg_write   (reg_write),
        .jal         (jal),
        .jr          (jr),
        .alu_src_imm (alu_src_imm),
        .mem_to_reg  (mem_to_reg),
        .reg_dst     (reg_dst),
        .alu_op      (alu_op),
        .illegal     (illegal),
        .bus_fault   (bus_fault)
    );

    assign obs = {imem_req, dmem_req, dmem_we, pc_en, reg_write, jal, jr,
                  alu_src_imm, mem_to_reg, reg_dst, alu_op, illegal, bus_fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, ncyc);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected vector with only the sticky flags set.
    function automatic logic [15:0] flags();
        logic [15:0] e;
        e = '0;
        e[1] = m_ill;
        e[0] = m_bf;
        return e;
    endfunction

    function automatic int kind_of(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        case (op)
            6'h00:   return (w[5:0] == 6'h08) ? K_JR : K_R;
            6'h02:   return K_J;
            6'h03:   return K_JAL;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h08:   return K_ADDI;
            6'h0D:   return K_ORI;
            default: return K_ILL;
        endcase
    endfunction

    // One clock: drive inputs, check outputs at the falling edge, advance.
    task automatic cyc(input string tag, input logic [15:0] exp, input bit iack, input bit dack);
        imem_ack   = iack;
        dmem_ack   = dack;
        imem_rdata = iack ? cur_word : $urandom;
        @(negedge clk);
        check(tag, 32'(obs), 32'(exp));
        check({tag, "_ir"}, instruction, m_inst);
        if (pc_en === 1'b1) pc_pulses++;
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        imem_ack = rb();
        dmem_ack = rb();
        @(posedge clk);
        #1;
        reset  = 1'b0;
        m_inst = '0;
        m_ill  = 1'b0;
        m_bf   = 1'b0;
        cyc("post_rst", flags(), rb(), rb());
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) cyc("halt", flags(), rb(), rb());
    endtask

    // Full expected schedule of one instruction given its ack delays.
    task automatic run_instr(input logic [31:0] w, input int df, input int dm,
                             input bit abort, output bit halted);
        int          k, nf, nm;
        logic [15:0] e;
        bit          ack;
        halted   = 1'b0;
        cur_word = w;
        k        = kind_of(w);
        nf       = (df >= int'(TO)) ? int'(TO) : df + 1;
        for (int i = 0; i < nf; i++) begin
            e = flags();
            e[B_IREQ] = 1'b1;
            cyc("fetch", e, (df < int'(TO)) && (i == df), rb());
        end
        if (df >= int'(TO)) begin
            m_bf = 1'b1;
            halted = 1'b1;
            return;
        end
        m_inst = w;
        cyc("decode", flags(), rb(), rb());
        if (k == K_ILL) begin
            m_ill = 1'b1;
            halted = 1'b1;
            return;
        end
        e = flags();
        case (k)
            K_R:                e[4:2] = 3'd5;
            K_ADDI, K_LW, K_SW: e[B_SRC] = 1'b1;
            K_ORI: begin
                e[4:2]   = 3'd3;
                e[B_SRC] = 1'b1;
            end
            default: ;
        endcase
        if (k == K_J || k == K_JR) begin
            e[B_PCE] = 1'b1;
            e[B_JR]  = (k == K_JR);
        end
        cyc("exec", e, rb(), rb());
        if (k == K_J || k == K_JR) begin
            retired++;
            return;
        end
        if (k == K_LW || k == K_SW) begin
            nm = (dm >= int'(TO)) ? int'(TO) : dm + 1;
            for (int i = 0; i < nm; i++) begin
                e = flags();
                e[B_DREQ] = 1'b1;
                e[B_DWE]  = (k == K_SW);
                if (abort && i == 1) begin
                    reset = 1'b1;
                    cyc("mem_rst", e, rb(), 1'b0);
                    reset  = 1'b0;
                    m_inst = '0;
                    m_ill  = 1'b0;
                    m_bf   = 1'b0;
                    cyc("post_rst", flags(), rb(), 1'b1);
                    return;
                end
                ack = (dm < int'(TO)) && (i == dm);
                e[B_PCE] = ack && (k == K_SW);
                cyc("mem", e, rb(), ack);
            end
            if (dm >= int'(TO)) begin
                m_bf = 1'b1;
                halted = 1'b1;
                return;
            end
            if (k == K_SW) begin
                retired++;
                return;
            end
        end
        e = flags();
        e[B_RW]  = 1'b1;
        e[B_PCE] = 1'b1;
        e[B_JAL] = (k == K_JAL);
        e[B_M2R] = (k == K_LW);
        e[6:5]   = (k == K_R) ? 2'd1 : (k == K_JAL) ? 2'd2 : 2'd0;
        cyc("wb", e, rb(), rb());
        retired++;
    endtask

    function automatic int rand_delay();
        if ($urandom_range(0, 15) == 0) return int'(TO) + int'($urandom_range(0, 2));
        return int'($urandom_range(0, TO - 1));
    endfunction

    initial begin
        logic [5:0]  ops [8];
        logic [31:0] w;
        bit          h;
        int          n0, sel;
        ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h23, 6'h2B, 6'h08, 6'h0D};
        errors = 0; checks = 0; ncyc = 0; pc_pulses = 0; retired = 0;
        m_inst = '0; m_ill = 1'b0; m_bf = 1'b0; cur_word = '0;
        reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("post_rst", flags(), rb(), rb());

        n0 = ncyc; run_instr(32'h012A4020, 0, 0, 1'b0, h);
        check("add_cpi", 32'(ncyc - n0), 32'd4);
        n0 = ncyc; run_instr(32'h8D090004, 0, 3, 1'b0, h);
        check("lw_cpi", 32'(ncyc - n0), 32'd8);
        n0 = ncyc; run_instr(32'h0C000010, 0, 0, 1'b0, h);
        check("jal_cpi", 32'(ncyc - n0), 32'd4);
        n0 = ncyc; run_instr(32'h03E00008, 0, 0, 1'b0, h);
        check("jr_cpi", 32'(ncyc - n0), 32'd3);
        n0 = ncyc; run_instr(32'hAD090004, 0, 0, 1'b0, h);
        check("sw_cpi", 32'(ncyc - n0), 32'd4);

        run_instr(32'hFC000000, 0, 0, 1'b0, h);
        check("ill_halt", 32'(h), 32'd1);
        halt_cycles(20);
        do_reset();
        run_instr(32'h012A4020, 0, 0, 1'b0, h);

        run_instr(32'h012A4020, int'(TO), 0, 1'b0, h);
        check("wdog_halt", 32'(h), 32'd1);
        halt_cycles(5);
        do_reset();
        n0 = ncyc; run_instr(32'h012A4020, int'(TO) - 1, 0, 1'b0, h);
        check("wdog_edge_ok", 32'(h), 32'd0);
        check("wdog_edge_cpi", 32'(ncyc - n0), 32'(4 + TO - 1));

        run_instr(32'hAD090004, 0, 5, 1'b1, h);
        run_instr(32'h34A5F00F, 0, 0, 1'b0, h);

        for (int t = 0; t < 300; t++) begin
            w   = $urandom;
            sel = int'($urandom_range(0, 9));
            if (sel < 8) w[31:26] = ops[sel];
            if (sel == 1) w[5:0] = 6'h08;
            run_instr(w, rand_delay(), rand_delay(), 1'b0, h);
            if (h) begin
                halt_cycles(3);
                do_reset();
            end
        end

        check("pc_per_retire", 32'(pc_pulses), 32'(retired));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control sequencer for the single-issue MIPS-subset datapath. It fetches one instruction per pass over an instruction-memory request/acknowledge handshake and holds it in an internal instruction register. It decodes the opcode and then drives the datapath's `reg_write`, `jal`, `jr`, PC-enable and ALU/mux selects in a fixed per-class state sequence. A bus watchdog turns a memory access that never completes into a sticky fault.

## Interface
- `TIMEOUT`, 255: maximum cycles any memory request may wait for its acknowledge; must satisfy 1..255.
- `clk` input 1: the single clock; every register updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `imem_ack` input 1: instruction memory has delivered `imem_rdata` this cycle.
- `imem_rdata` input 32: instruction word; sampled only when `imem_ack`=1 in FETCH.
- `dmem_ack` input 1: data memory access is complete this cycle.
- `imem_req` output 1: instruction fetch request.
- `dmem_req` output 1: data memory request.
- `dmem_we` output 1: data memory write; valid only while `dmem_req`=1.
- `instruction` output 32: the instruction register, which feeds the datapath.
- `pc_en` output 1: one-cycle PC update strobe.
- `reg_write` output 1: register-file write strobe.
- `jal` output 1: jump-and-link select.
- `jr` output 1: jump-register select.
- `alu_src_imm` output 1: ALU B operand is the sign-extended immediate.
- `mem_to_reg` output 1: writeback data is the load data.
- `reg_dst` output 2: write-register select; 0 = rt, 1 = rd, 2 = r31.
- `alu_op` output 3: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 funct-decoded.
- `illegal` output 1: sticky; an unsupported opcode was decoded.
- `bus_fault` output 1: sticky; the watchdog expired.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset state is FETCH. On reset every output is 0, `instruction`=0 and the watchdog count is 0.
- FETCH:
  - `imem_req`=1.
  - On `imem_ack`, load `imem_rdata` into `instruction` and go to DECODE.
- DECODE classifies the instruction from opcode `[31:26]`:
  - 000000 with funct 001000 → JR.
  - Any other 000000 → RTYPE.
  - 000010 → J.
  - 000011 → JAL.
  - 100011 → LW.
  - 101011 → SW.
  - 001000 → ADDI.
  - 001101 → ORI.
  - Anything else → illegal: set `illegal` and go to HALT.
- EXEC:
  - `alu_op` and `alu_src_imm` are driven per class. RTYPE uses `alu_op`=5. ADDI, LW and SW use add with the immediate. ORI uses or with the immediate.
  - J: `pc_en`=1, then FETCH.
  - JR: `pc_en`=1 and `jr`=1, then FETCH.
  - JAL: go to WB.
  - LW and SW: go to MEM.
  - RTYPE, ADDI and ORI: go to WB.
- MEM:
  - `dmem_req`=1; `dmem_we`=1 for SW.
  - On `dmem_ack`, LW goes to WB. SW asserts `pc_en` in that same cycle and goes to FETCH.
- WB:
  - `reg_write`=1 and `pc_en`=1 for exactly one cycle, then FETCH.
  - `reg_dst`: RTYPE=1, JAL=2, all others=0.
  - `mem_to_reg`=1 for LW only.
  - JAL also asserts `jal` in this cycle.
- HALT:
  - Absorbing state. All strobes are 0. `illegal` and `bus_fault` are held.
  - Only `reset` leaves HALT.
- Watchdog:
  - The count is cleared on entry to FETCH or MEM and increments each cycle without an ack.
  - When the count reaches `TIMEOUT` with no ack in that cycle, set `bus_fault`, drop the request and go to HALT.
  - An ack in the same cycle the count reaches `TIMEOUT` wins: no fault is raised.

## Timing
- All outputs are Moore-decoded from state and the latched class. The one exception: the SW `pc_en` and the MEM→WB/FETCH transition qualify on `dmem_ack`, because the datapath PC is edge-updated.
- `imem_req` rises in the first cycle after reset deasserts.
- Cycles per instruction with zero-wait memory (ack in the first request cycle):
  - J, JR: 3.
  - RTYPE, ADDI, ORI, JAL: 4.
  - SW: 4.
  - LW: 5.
- Each ack wait cycle adds 1 cycle.
- `instruction` is stable from DECODE until the next FETCH ack.
- `jal` and `jr` are asserted only in the same cycle as `pc_en`.
- `pc_en` pulses exactly once per retired instruction and never in HALT.
- `reset` asserted in any state, including mid-MEM with `dmem_req` high, returns to FETCH on the next edge. All outputs are 0 in that following cycle. A late ack arriving after reset is ignored until FETCH next requests.
- Request/ack handshake rules:
  - Acks arriving in states that are not requesting are ignored.
  - A request stays high until its ack or a timeout. It is never withdrawn otherwise.

## Structure
- Shared package `mips_pkg`, containing:
  - Opcode constants and the JR funct constant.
  - The `alu_op` encodings.
  - The `reg_dst` encodings.
  - The state enum and the instruction-class enum.
- The decode is split into one combinational sub-module, `mips_mc_decode`: opcode/funct → class and illegal flag. The controller itself is a single FSM module that instantiates `mips_mc_decode`.

## Test plan
- R-type: `add` 0x012A4020 with the ack on the first request cycle → 4-cycle sequence; `reg_write`=1, `reg_dst`=1 and `pc_en`=1 together in the WB cycle.
- LW: 0x8D090004 with `dmem_ack` delayed 3 cycles → `dmem_req` high for 4 cycles, `dmem_we`=0, then WB with `mem_to_reg`=1; 8 cycles total.
- JAL and JR:
  - JAL 0x0C000010 → `jal`=1, `reg_dst`=2, `reg_write`=1 and `pc_en`=1 in the same single cycle.
  - JR 0x03E00008 → `jr`=1 with `pc_en` in EXEC, and `reg_write` stays 0.
- Illegal opcode 0xFC000000 → `illegal`=1 and HALT; no `pc_en` for the next 20 cycles; `reset` clears `illegal` and `imem_req` returns.
- Watchdog with `TIMEOUT`=4:
  - `imem_ack` withheld → `bus_fault`=1 after 4 wait cycles and `imem_req` drops.
  - Repeat with the ack arriving exactly in the 4th wait cycle → no fault.
- `reset` asserted mid-MEM of an SW → the next cycle has all outputs 0 and the FSM in FETCH; a stray `dmem_ack` one cycle later causes no `pc_en`.
